// File: rtl/gate_vector_checker.sv
// Sweeps {a,b} through 00..11 for PASSES rounds, compares seven gate responses
// against a golden model and reports error count plus the first failing vector.
module gate_vector_checker #(
    parameter int SETTLE = 2,
    parameter int PASSES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       and_out,
    input  logic       or_out,
    input  logic       nand_out,
    input  logic       nor_out,
    input  logic       notb_out,
    input  logic       xor_out,
    input  logic       xnor_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [1:0] first_fail_vec,
    output logic [6:0] first_fail_mask,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_SETTLE = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(SETTLE - 1);
    localparam logic [7:0] PASS_LAST = 8'(PASSES - 1);

    state_t     state_q;
    logic       a_q, b_q, busy_q, done_q, pass_q;
    logic [7:0] err_count_q, err_count_d;
    logic [1:0] ffv_q, idx_q;
    logic [6:0] ffm_q;
    logic [3:0] wait_q;
    logic [7:0] pass_cnt_q;
    logic [6:0] golden, resp, mask;
    logic       last_vec;

    // Bit order {and,or,nand,nor,notb,xor,xnor}.
    assign golden = {a_q & b_q, a_q | b_q, ~(a_q & b_q), ~(a_q | b_q),
                     ~b_q, a_q ^ b_q, ~(a_q ^ b_q)};
    assign resp   = {and_out, or_out, nand_out, nor_out, notb_out, xor_out, xnor_out};

    always_comb begin
        mask = golden ^ resp;
`ifndef SYNTHESIS
        // An undriven or unknown response is a failure, never a silent pass.
        for (int i = 0; i < 7; i++) begin
            if ($isunknown(resp[i])) mask[i] = 1'b1;
        end
`endif
    end

    assign err_count_d = (err_count_q == 8'hFF) ? 8'hFF : err_count_q + 8'd1;
    assign last_vec    = (idx_q == 2'd3) && (pass_cnt_q == PASS_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= 8'd0;
            ffv_q       <= 2'd0;
            ffm_q       <= 7'd0;
            idx_q       <= 2'd0;
            wait_q      <= 4'd0;
            pass_cnt_q  <= 8'd0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q     <= S_DRIVE;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        err_count_q <= 8'd0;
                        ffv_q       <= 2'd0;
                        ffm_q       <= 7'd0;
                        idx_q       <= 2'd0;
                        pass_cnt_q  <= 8'd0;
                    end
                end
                S_DRIVE: begin
                    {a_q, b_q} <= idx_q;
                    wait_q     <= 4'd0;
                    state_q    <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (wait_q == WAIT_LAST) state_q <= S_CHECK;
                    else                     wait_q  <= wait_q + 4'd1;
                end
                S_CHECK: begin
                    if (mask != 7'd0) begin
                        err_count_q <= err_count_d;
                        // err_count saturates, so zero means no failure yet this run.
                        if (err_count_q == 8'd0) begin
                            ffv_q <= {a_q, b_q};
                            ffm_q <= mask;
                        end
                    end
                    idx_q <= idx_q + 2'd1;
                    if (last_vec) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (mask == 7'd0) && (err_count_q == 8'd0);
                    end else begin
                        state_q <= S_DRIVE;
                        if (idx_q == 2'd3) pass_cnt_q <= pass_cnt_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign a               = a_q;
    assign b               = b_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_count_q;
    assign first_fail_vec  = ffv_q;
    assign first_fail_mask = ffm_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Directed bench: three checker instances (2/1, 2/100, 1/2) each driving a
// behavioural gate block whose fault mode is chosen per test.
module tb_gate_vector_checker;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // fault mode: 0 = correct gates, 1 = xor_out stuck at 0, 2 = all inverted
    function automatic logic [6:0] gate_model(input logic a, input logic b, input int mode);
        logic [6:0] g;
        g = {a & b, a | b, ~(a & b), ~(a | b), ~b, a ^ b, ~(a ^ b)};
        if (mode == 1) g[1] = 1'b0;
        if (mode == 2) g = ~g;
        return g;
    endfunction

    // ---------------- instance 0: SETTLE=2 PASSES=1 ----------------
    logic start0 = 1'b0;
    int mode0 = 0;
    logic a0, b0, busy0, done0, pass0;
    logic [7:0] err0;
    logic [1:0] ffv0;
    logic [6:0] ffm0, r0;
    logic [2:0] st0;
    assign r0 = gate_model(a0, b0, mode0);

    gate_vector_checker #(.SETTLE(2), .PASSES(1)) u0 (
        .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0),
        .and_out(r0[6]), .or_out(r0[5]), .nand_out(r0[4]), .nor_out(r0[3]),
        .notb_out(r0[2]), .xor_out(r0[1]), .xnor_out(r0[0]),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_fail_vec(ffv0), .first_fail_mask(ffm0), .dbg_state(st0));

    // ---------------- instance 1: SETTLE=2 PASSES=100 ----------------
    logic start1 = 1'b0;
    int mode1 = 2;
    logic a1, b1, busy1, done1, pass1;
    logic [7:0] err1;
    logic [1:0] ffv1;
    logic [6:0] ffm1, r1;
    logic [2:0] st1;
    assign r1 = gate_model(a1, b1, mode1);

    gate_vector_checker #(.SETTLE(2), .PASSES(100)) u1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .and_out(r1[6]), .or_out(r1[5]), .nand_out(r1[4]), .nor_out(r1[3]),
        .notb_out(r1[2]), .xor_out(r1[1]), .xnor_out(r1[0]),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail_vec(ffv1), .first_fail_mask(ffm1), .dbg_state(st1));

    // ---------------- instance 2: SETTLE=1 PASSES=2 ----------------
    logic start2 = 1'b0;
    int mode2 = 0;
    logic a2, b2, busy2, done2, pass2;
    logic [7:0] err2;
    logic [1:0] ffv2;
    logic [6:0] ffm2, r2;
    logic [2:0] st2;
    assign r2 = gate_model(a2, b2, mode2);

    gate_vector_checker #(.SETTLE(1), .PASSES(2)) u2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
        .and_out(r2[6]), .or_out(r2[5]), .nand_out(r2[4]), .nor_out(r2[3]),
        .notb_out(r2[2]), .xor_out(r2[1]), .xnor_out(r2[0]),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .first_fail_vec(ffv2), .first_fail_mask(ffm2), .dbg_state(st2));

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic sel_done(input int inst);
        case (inst)
            0: return done0;
            1: return done1;
            default: return done2;
        endcase
    endfunction

    function automatic logic [2:0] sel_state(input int inst);
        case (inst)
            0: return st0;
            1: return st1;
            default: return st2;
        endcase
    endfunction

    // Pulses start for one edge; leaves the bench at the negedge after that edge.
    task automatic pulse_start(input int inst);
        @(negedge clk);
        case (inst)
            0: start0 = 1'b1;
            1: start1 = 1'b1;
            default: start2 = 1'b1;
        endcase
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    // Called at the negedge after the start-sampling edge; returns edges until done.
    // For instance 0, also checks the {a,b} sequence cycle by cycle.
    task automatic wait_done(input int inst, input int limit, input bit chk_ab,
                             output int cycles, output int nchecks);
        int exp_ab;
        cycles = 0;
        nchecks = 0;
        while (!sel_done(inst) && cycles < limit) begin
            if (sel_state(inst) == 3'd3) nchecks++;
            @(negedge clk);
            cycles++;
            if (chk_ab) begin
                exp_ab = (cycles - 1) / 4;
                if (exp_ab > 3) exp_ab = 3;
                check($sformatf("ab_k%0d", cycles), {a0, b0}, exp_ab);
            end
        end
        if (!sel_done(inst)) check("done_timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    int cyc, nchk;

    initial begin
        do_reset();

        // Reset state
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_pass", pass0, 0);
        check("rst_err",  err0, 0);
        check("rst_ab",   {a0, b0}, 0);
        check("rst_ffv",  ffv0, 0);
        check("rst_ffm",  ffm0, 0);
        check("rst_state", st0, 0);

        // Clean sweep with cycle-level {a,b} check
        mode0 = 0;
        pulse_start(0);
        check("run_busy", busy0, 1);
        wait_done(0, 100, 1'b1, cyc, nchk);
        check("lat_clean", cyc, 16);
        check("clean_pass", pass0, 1);
        check("clean_err", err0, 0);
        check("clean_busy", busy0, 0);

        // xor_out stuck at 0
        mode0 = 1;
        pulse_start(0);
        check("restart_err_clr", err0, 0);
        wait_done(0, 100, 1'b0, cyc, nchk);
        check("xor_err", err0, 2);
        check("xor_ffv", ffv0, 2'b01);
        check("xor_ffm", ffm0, 7'b0000010);
        check("xor_pass", pass0, 0);

        // DONE holds results and last vector
        repeat (5) @(negedge clk);
        check("hold_done", done0, 1);
        check("hold_err", err0, 2);
        check("hold_ab", {a0, b0}, 2'b11);

        // Start in DONE clears counters and restarts
        mode0 = 0;
        pulse_start(0);
        check("rs_err", err0, 0);
        check("rs_ffm", ffm0, 0);
        check("rs_ffv", ffv0, 0);
        check("rs_done", done0, 0);
        check("rs_busy", busy0, 1);
        wait_done(0, 100, 1'b0, cyc, nchk);
        check("rs_pass", pass0, 1);

        // start held high through a whole run: no restart while busy
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        wait_done(0, 100, 1'b0, cyc, nchk);
        start0 = 1'b0;
        check("held_lat", cyc, 16);
        check("held_pass", pass0, 1);

        // Mid-run reset while {a,b}=10 in SETTLE
        @(negedge clk);
        mode0 = 1;
        pulse_start(0);
        repeat (9) @(negedge clk);
        check("mid_ab", {a0, b0}, 2'b10);
        check("mid_state", st0, 3'd2);
        check("mid_err", err0, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_state", st0, 0);
        check("mid_rst_busy", busy0, 0);
        check("mid_rst_ab", {a0, b0}, 0);
        check("mid_rst_err", err0, 0);
        check("mid_rst_ffv", ffv0, 0);
        check("mid_rst_ffm", ffm0, 0);
        check("mid_rst_done", done0, 0);
        mode0 = 0;
        pulse_start(0);
        wait_done(0, 100, 1'b0, cyc, nchk);
        check("post_rst_pass", pass0, 1);
        check("post_rst_err", err0, 0);

        // All inverted, 100 passes: saturation
        mode1 = 2;
        pulse_start(1);
        wait_done(1, 2000, 1'b0, cyc, nchk);
        check("sat_lat", cyc, 1600);
        check("sat_err", err1, 255);
        check("sat_ffv", ffv1, 2'b00);
        check("sat_ffm", ffm1, 7'b1111111);
        check("sat_pass", pass1, 0);

        // SETTLE=1, PASSES=2
        mode2 = 0;
        pulse_start(2);
        wait_done(2, 100, 1'b0, cyc, nchk);
        check("s1p2_lat", cyc, 24);
        check("s1p2_checks", nchk, 8);
        check("s1p2_pass", pass2, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/gate_vector_checker.md
GATE_VECTOR_CHECKER -- requirements
Module: gate_vector_checker

Interface
REQ-001 The block SHALL have parameter SETTLE, default 2, giving the wait cycles between driving a vector and sampling the responses; legal range 1..15.
REQ-002 The block SHALL have parameter PASSES, default 1, giving the number of full 4-vector sweeps per run; legal range 1..255.
REQ-003 The block SHALL have the port clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have the port rst  in  1  reset; synchronous, active-high.
REQ-005 The block SHALL have the port start  in  1  run request; sampled only in IDLE or DONE.
REQ-006 The block SHALL have the port a  out  1  stimulus to the gate block; registered; MSB of the vector.
REQ-007 The block SHALL have the port b  out  1  stimulus to the gate block; registered; LSB of the vector.
REQ-008 The block SHALL have the ports and_out, or_out, nand_out, nor_out, notb_out, xor_out, xnor_out  in  1 each  gate-block responses.
REQ-009 The block SHALL have the port busy  out  1  high in DRIVE, SETTLE and CHECK.
REQ-010 The block SHALL have the port done  out  1  high while in DONE.
REQ-011 The block SHALL have the port pass  out  1  high in DONE when err_count==0; low otherwise.
REQ-012 The block SHALL have the port err_count  out  8  count of failing vectors; saturating.
REQ-013 The block SHALL have the port first_fail_vec  out  2  {a,b} of the first failing vector in the run.
REQ-014 The block SHALL have the port first_fail_mask  out  7  mismatch mask of that vector; bit order {and,or,nand,nor,notb,xor,xnor}, bits 6..0.

Function
REQ-015 The FSM SHALL have the states IDLE, DRIVE, SETTLE, CHECK and DONE.
REQ-016 IDLE or DONE with start=1 SHALL move to DRIVE and, at the same edge, clear err_count, first_fail_vec, first_fail_mask, the vector index and the pass counter.
REQ-017 While busy, start SHALL be ignored.
REQ-018 DRIVE SHALL register {a,b} <= vector index, then move to SETTLE with the wait counter cleared.
REQ-019 SETTLE SHALL remain for exactly SETTLE cycles, then move to CHECK.
REQ-020 CHECK SHALL compute the golden values from the registered a,b: and=a&b, or=a|b, nand=~(a&b), nor=~(a|b), notb=~b, xor=a^b, xnor=~(a^b).
REQ-021 In CHECK, mask SHALL equal golden XOR inputs.
REQ-022 In CHECK with mask!=0, err_count SHALL increment, saturating at 255.
REQ-023 In CHECK with mask!=0 and this as the first failure of the run, first_fail_vec and first_fail_mask SHALL be latched; later failures SHALL NOT overwrite them.
REQ-024 CHECK SHALL increment the vector index 0..3; on the 3->0 wrap the pass counter SHALL increment.
REQ-025 CHECK SHALL move to DONE after vector 3 of pass PASSES, and to DRIVE otherwise.
REQ-026 Latency: each vector SHALL occupy SETTLE+2 cycles; done SHALL first be high 4*PASSES*(SETTLE+2) edges after the edge that samples start.
REQ-027 DONE SHALL hold done=1 and all result outputs stable until start or rst.
REQ-028 In DONE, a and b SHALL hold the last vector.
REQ-029 A sampled X/Z on any response input SHALL count as a mismatch, in simulation only.

Reset
REQ-030 With rst=1 at an edge, that edge SHALL put the FSM in IDLE and zero a, b, busy, done, pass, err_count, first_fail_vec and first_fail_mask.
REQ-031 rst SHALL take priority over start and over any in-progress run; a mid-run reset SHALL abort the run without reporting.

Verification
REQ-032 Correct gate model, SETTLE=2, PASSES=1, start pulse -> {a,b}=00,01,10,11 each held 4 cycles; done high 16 cycles after start; pass=1; err_count=0.
REQ-033 xor_out stuck at 0 -> err_count=2; first_fail_vec=01; first_fail_mask=0000010; pass=0.
REQ-034 All responses inverted, PASSES=100 -> err_count=255 (saturated); first_fail_vec=00; first_fail_mask=1111111.
REQ-035 rst pulsed while {a,b}=10 in SETTLE -> next cycle IDLE, busy=0, all outputs 0; a following start completes a clean sweep with pass=1.
REQ-036 start held high throughout a run -> no restart while busy; run completes normally; a start in DONE restarts with counters cleared.
REQ-037 SETTLE=1, PASSES=2 -> done high 24 cycles after start; eight CHECK evaluations.
